ps2_keycode_rx: RTL and testbench

//  PS/2 keyboard receiver and scan-code decoder. Deserialises device-to-host frames and tracks
//  the single most recent held key. Produces the level-style keycode (0 = no key) and the hold

---
 rtl/ps2_keycode_rx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host frame receiver with scan-code decode: tracks the most recent held key,
// its E0 prefix and a hold flag that asserts after the key has been down long enough.
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int HOLD_CYCLES    = 25000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       hold,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  // input path
  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          clk_filt_q, clk_filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          clk_s, sdat, fall;

  // frame FSM and datapath
  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          par_q, par_d;
  logic          byte_vld_q, byte_vld_d;
  logic          ferr_q, ferr_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_hit;

  // decoder
  logic [7:0]    keycode_q, keycode_d;
  logic          extended_q, extended_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic          cv_q, cv_d;
  logic          hold_q, hold_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          match;

  // The filtered clock only follows the synced line once it has disagreed for FILTER_LEN
  // consecutive samples; any agreeing sample restarts the count.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    clk_s      = clk_sync_q[1];
    sdat       = dat_sync_q[1];
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_s != clk_filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) clk_filt_d = clk_s;
      else                                   filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall = clk_filt_q & ~clk_filt_d;
  end

  assign tmo_hit = (state_q != IDLE) && !fall && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!sdat) state_d = DATA;
        DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    par_d      = par_q;
    byte_vld_d = 1'b0;
    ferr_d     = 1'b0;
    tmo_cnt_d  = (state_q == IDLE || fall) ? '0 : tmo_cnt_q + 1'b1;
    if (tmo_hit) begin
      ferr_d = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE:   bitcnt_d = 3'd0;
        DATA: begin
          shift_d  = {sdat, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
        end
        PARITY: par_d = sdat;
        STOP: begin
          if (sdat && (^{shift_q, par_q})) byte_vld_d = 1'b1;
          else                             ferr_d     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Prefix bytes only arm flags; a key match is judged against the currently tracked code.
  always_comb begin
    keycode_d  = keycode_q;
    extended_d = extended_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    cv_d       = 1'b0;
    match      = (shift_q == keycode_q) && (ext_q == extended_q);
    if (byte_vld_q) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shift_q inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (brk_q) begin
          if (match) begin
            keycode_d  = 8'h00;
            extended_d = 1'b0;
            cv_d       = 1'b1;
          end
        end else if (!match) begin
          keycode_d  = shift_q;
          extended_d = ext_q;
          cv_d       = 1'b1;
        end
      end
    end
  end

  // Any keycode change (new key or release) restarts the timer; typematic repeats do not.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (cv_d || keycode_q == 8'h00)              hold_cnt_d = '0;
    else if (hold_cnt_q != HW'(HOLD_CYCLES))     hold_cnt_d = hold_cnt_q + 1'b1;
    hold_d = (hold_cnt_d == HW'(HOLD_CYCLES)) && (keycode_d != 8'h00);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      shift_q    <= 8'h00;
      bitcnt_q   <= 3'd0;
      par_q      <= 1'b0;
      byte_vld_q <= 1'b0;
      ferr_q     <= 1'b0;
      tmo_cnt_q  <= '0;
      keycode_q  <= 8'h00;
      extended_q <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      cv_q       <= 1'b0;
      hold_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      par_q      <= par_d;
      byte_vld_q <= byte_vld_d;
      ferr_q     <= ferr_d;
      tmo_cnt_q  <= tmo_cnt_d;
      keycode_q  <= keycode_d;
      extended_q <= extended_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      cv_q       <= cv_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign keycode    = keycode_q;
  assign extended   = extended_q;
  assign hold       = hold_q;
  assign code_valid = cv_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Scoreboard bench for ps2_keycode_rx: stimulus pushes expected code_valid/frame_err events,
// an independent monitor pops and compares them as the DUT produces them.
module tb_ps2_keycode_rx;
  localparam int FL = 4;
  localparam int TO = 2000;
  localparam int HC = 1000;
  localparam int BP = 200;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       extended, hold, code_valid, frame_err;

  ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .HOLD_CYCLES(HC)) dut (
    .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .extended(extended), .hold(hold),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {logic is_err; logic [7:0] kc; logic ext;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  int cv_cyc = -1, fe_cyc = -1, fall_drv = 0;

  always @(negedge Clk) begin
    if (!Reset) begin
      if (code_valid) begin
        cv_cyc = cyc;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_code_valid got kc=%h ext=%b expected no event", keycode, extended);
        end else begin
          e = q.pop_front();
          if (e.is_err || e.kc !== keycode || e.ext !== extended) begin
            errors++;
            $display("FAIL code_valid got kc=%h ext=%b expected err=%b kc=%h ext=%b",
                     keycode, extended, e.is_err, e.kc, e.ext);
          end
        end
      end
      if (frame_err) begin
        fe_cyc = cyc;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_err got frame_err=1 expected no event");
        end else begin
          e = q.pop_front();
          if (!e.is_err) begin
            errors++;
            $display("FAIL frame_err got frame_err expected code kc=%h ext=%b", e.kc, e.ext);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic waitc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    waitc(BP / 4);
    ps2_clk  = 1'b0;
    fall_drv = cyc;
    waitc(BP / 2);
    ps2_clk  = 1'b1;
    waitc(BP / 4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    ps2_data = 1'b1;
    waitc(100);
  endtask

  task automatic push_cv(input logic [7:0] kc, input logic ext);
    q.push_back('{1'b0, kc, ext});
  endtask

  task automatic push_fe();
    q.push_back('{1'b1, 8'h00, 1'b0});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      waitc(1);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s got %0d pending events expected 0", nm, q.size());
      q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish expected finish before time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int lat;
    waitc(5);
    chk("reset_outputs", {keycode, extended, hold, code_valid, frame_err}, 32'h0);
    Reset = 1'b0;
    waitc(20);

    // make / break, F0 alone produces nothing
    push_cv(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    drain("t1_make");
    chk("t1_keycode", keycode, 32'h1C);
    send_byte(8'hF0, 1'b0);
    push_cv(8'h00, 1'b0);
    send_byte(8'h1C, 1'b0);
    drain("t1_break");
    chk("t1_hold_released", hold, 32'h0);

    // extended key; plain break of same code ignored
    push_cv(8'h75, 1'b1);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    drain("t2_make");
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    chk("t2_plain_break_ignored", {keycode, extended}, {23'h0, 8'h75, 1'b1});
    push_cv(8'h00, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    drain("t2_break");

    // parity error then a good frame
    push_fe();
    send_byte(8'h1C, 1'b1);
    drain("t3_parity");
    chk("t3_keycode_after_err", keycode, 32'h0);
    push_cv(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    drain("t3_good");
    push_cv(8'h00, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    drain("t3_release");

    // hold timing and typematic repeats
    push_cv(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    drain("t4_make");
    while (cyc < cv_cyc + HC - 1) waitc(1);
    chk("t4_hold_before", hold, 32'h0);
    waitc(1);
    chk("t4_hold_at", hold, 32'h1);
    for (int r = 0; r < 2; r++) begin
      waitc(200);
      send_byte(8'h1C, 1'b0);
      chk("t4_hold_repeat", hold, 32'h1);
    end
    push_cv(8'h00, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    drain("t4_release");
    chk("t4_hold_off", hold, 32'h0);

    // timeout after 5 bits
    fe_cyc = -1;
    push_fe();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    drain("t5_timeout");
    lat = fe_cyc - fall_drv;
    checks++;
    if (lat < TO + 4 || lat > TO + 8) begin
      errors++;
      $display("FAIL t5_timeout_latency got %0d expected %0d..%0d", lat, TO + 4, TO + 8);
    end
    waitc(100);
    push_cv(8'h2B, 1'b0);
    send_byte(8'h2B, 1'b0);
    drain("t5_after");
    push_cv(8'h00, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h2B, 1'b0);
    drain("t5_release");

    // glitch then frame, which would misalign if the glitch were taken as a start bit
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    waitc(2);
    ps2_clk  = 1'b1;
    waitc(2);
    ps2_data = 1'b1;
    waitc(50);
    push_cv(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    drain("t6_glitch");

    // reset mid-frame while a key is held
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    Reset = 1'b1;
    waitc(2);
    chk("t6_reset_outputs", {keycode, extended, hold, code_valid, frame_err}, 32'h0);
    ps2_data = 1'b1;
    Reset = 1'b0;
    waitc(50);
    push_cv(8'h2B, 1'b0);
    send_byte(8'h2B, 1'b0);
    drain("t6_after_reset");
    chk("t6_keycode", {keycode, extended}, {23'h0, 8'h2B, 1'b0});

    waitc(100);
    chk("final_queue_empty", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
